conv_mac_sequencer: RTL and testbench

// - Nios II multi-cycle custom instruction that sequences a TAPS-tap FIR convolution over one shared 16x16 MAC.
// - Owns the sample history (circular register buffer), the coefficient bank and the control FSM.
// - Sits on the CPU custom-instruction port and replaces a plain delay line with a complete filter step per call.

---
 rtl/conv_mac_sequencer.sv | 154 +++++++++++++++
 tb/tb_conv_mac_sequencer.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/conv_mac_sequencer.sv
// conv_mac_sequencer
//   Multi-cycle custom instruction that runs one FIR filter step per call over a single
//   shared 16x16 signed MAC. It owns the sample history, the coefficient bank and the
//   sequencing FSM.
//
// Ports
//   clk     system clock
//   reset   synchronous active-high reset; overrides clk_en
//   clk_en  clock enable; low freezes every register
//   start   instruction start pulse, accepted only in IDLE
//   dataa   [15:0] sample or coefficient value
//   datab   [1:0] opcode (00 FILTER, 01 WR_COEF, 10 CLR_HIST, 11 RD_COEF), [15:8] tap index
//   result  instruction result, updated together with done and held until the next done
//   done    completion pulse, high for one enabled cycle

module conv_mac_sequencer #(
    parameter int unsigned TAPS  = 32,
    parameter int unsigned ACC_W = 40
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        clk_en,
    input  logic        start,
    input  logic [31:0] dataa,
    input  logic [31:0] datab,
    output logic [31:0] result,
    output logic        done
);

    localparam int unsigned IdxW = $clog2(TAPS);

    localparam logic [1:0] StIdle  = 2'd0;
    localparam logic [1:0] StMac   = 2'd1;
    localparam logic [1:0] StRound = 2'd2;
    localparam logic [1:0] StDone  = 2'd3;

    localparam logic [1:0] OpFilter  = 2'b00;
    localparam logic [1:0] OpWrCoef  = 2'b01;
    localparam logic [1:0] OpClrHist = 2'b10;
    localparam logic [1:0] OpRdCoef  = 2'b11;

    localparam logic signed [ACC_W-1:0] RoundBias = ACC_W'(16384);
    localparam logic signed [ACC_W-1:0] SatMax    = ACC_W'(32767);
    localparam logic signed [ACC_W-1:0] SatMin    = ~SatMax;

    logic [1:0]              state_q;
    logic [IdxW-1:0]         wr_ptr_q;
    logic [IdxW-1:0]         k_q;
    logic signed [ACC_W-1:0] acc_q;
    logic [31:0]             result_q;
    logic signed [15:0]      hist_q [TAPS];
    logic signed [15:0]      coef_q [TAPS];

    logic [IdxW-1:0]         tap_idx;
    logic [IdxW-1:0]         op_idx;
    logic signed [15:0]      hist_tap;
    logic signed [15:0]      coef_tap;
    logic signed [31:0]      prod;
    logic signed [ACC_W-1:0] acc_rnd;
    logic signed [ACC_W-1:0] acc_shr;
    logic [15:0]             y;
    logic                    unused_bits;

    // Upper operand bits carry no meaning for this instruction.
    assign unused_bits = ^{dataa[31:16], datab[31:2]};

    always_comb begin
        // Newest sample pairs with coef[0]; the subtraction wraps modulo TAPS by width.
        tap_idx  = wr_ptr_q - k_q;
        op_idx   = datab[8 +: IdxW];
        hist_tap = hist_q[tap_idx];
        coef_tap = coef_q[k_q];
        prod     = 32'(hist_tap) * 32'(coef_tap);

        // Round half up in Q1.15, then saturate to the 16-bit signed range.
        acc_rnd = acc_q + RoundBias;
        acc_shr = acc_rnd >>> 15;
        if (acc_shr > SatMax) begin
            y = 16'h7FFF;
        end else if (acc_shr < SatMin) begin
            y = 16'h8000;
        end else begin
            y = acc_shr[15:0];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= StIdle;
            wr_ptr_q <= '0;
            k_q      <= '0;
            acc_q    <= '0;
            result_q <= '0;
            for (int i = 0; i < TAPS; i++) begin
                hist_q[i] <= '0;
                coef_q[i] <= '0;
            end
        end else if (clk_en) begin
            case (state_q)
                StIdle: begin
                    if (start) begin
                        unique case (datab[1:0])
                            OpFilter: begin
                                hist_q[wr_ptr_q] <= dataa[15:0];
                                k_q              <= '0;
                                acc_q            <= '0;
                                state_q          <= StMac;
                            end
                            OpWrCoef: begin
                                coef_q[op_idx] <= dataa[15:0];
                                result_q       <= '0;
                                state_q        <= StDone;
                            end
                            OpClrHist: begin
                                for (int i = 0; i < TAPS; i++) begin
                                    hist_q[i] <= '0;
                                end
                                wr_ptr_q <= '0;
                                result_q <= '0;
                                state_q  <= StDone;
                            end
                            OpRdCoef: begin
                                result_q <= {{16{coef_q[op_idx][15]}}, coef_q[op_idx]};
                                state_q  <= StDone;
                            end
                        endcase
                    end
                end
                StMac: begin
                    acc_q <= acc_q + {{(ACC_W - 32){prod[31]}}, prod};
                    k_q   <= k_q + IdxW'(1);
                    if (k_q == IdxW'(TAPS - 1)) begin
                        state_q <= StRound;
                    end
                end
                StRound: begin
                    result_q <= {{16{y[15]}}, y};
                    wr_ptr_q <= wr_ptr_q + IdxW'(1);
                    state_q  <= StDone;
                end
                StDone: begin
                    state_q <= StIdle;
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

    assign done   = (state_q == StDone);
    assign result = result_q;

endmodule

// File: tb/tb_conv_mac_sequencer.sv
// Bench for conv_mac_sequencer: directed steps with a reference model feeding an expected-result
// queue, popped and compared whenever the DUT raises done.

module tb_conv_mac_sequencer;

    localparam int TAPS  = 32;
    localparam int ACC_W = 40;

    logic        clk = 1'b0;
    logic        reset;
    logic        clk_en;
    logic        start;
    logic [31:0] dataa;
    logic [31:0] datab;
    logic [31:0] result;
    logic        done;

    conv_mac_sequencer #(
        .TAPS  (TAPS),
        .ACC_W (ACC_W)
    ) dut (
        .clk    (clk),
        .reset  (reset),
        .clk_en (clk_en),
        .start  (start),
        .dataa  (dataa),
        .datab  (datab),
        .result (result),
        .done   (done)
    );

    always #5 clk = ~clk;

    int          tests = 0;
    int          fails = 0;
    logic [31:0] exp_q[$];

    shortint m_hist[TAPS];
    shortint m_coef[TAPS];
    int      m_wp;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        tests++;
        assert (obs === expv) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    function automatic void model_reset();
        for (int i = 0; i < TAPS; i++) begin
            m_hist[i] = 0;
            m_coef[i] = 0;
        end
        m_wp = 0;
    endfunction

    function automatic logic [31:0] model_filter(input logic [15:0] s);
        longint acc = 0;
        longint yv;
        m_hist[m_wp] = shortint'(s);
        for (int k = 0; k < TAPS; k++) begin
            acc += longint'(m_hist[(m_wp - k) & (TAPS - 1)]) * longint'(m_coef[k]);
        end
        yv = (acc + 64'sd16384) >>> 15;
        if (yv > 32767) yv = 32767;
        if (yv < -32768) yv = -32768;
        m_wp = (m_wp + 1) % TAPS;
        return 32'(yv);
    endfunction

    function automatic logic [31:0] model_op(input logic [1:0] op, input logic [15:0] a,
                                             input logic [7:0] idx);
        logic [31:0] r;
        r = 32'h0;
        case (op)
            2'b00: r = model_filter(a);
            2'b01: m_coef[int'(idx) % TAPS] = shortint'(a);
            2'b10: begin
                for (int i = 0; i < TAPS; i++) m_hist[i] = 0;
                m_wp = 0;
            end
            default: r = 32'(int'(m_coef[int'(idx) % TAPS]));
        endcase
        return r;
    endfunction

    // Issues one instruction, waits (bounded) for done, checks result, latency and pulse width.
    // toggle: randomise clk_en while busy and inject a stray start mid-MAC.
    // use_fix: expect the given constant rather than the model value.
    task automatic run_op(input logic [1:0] op, input logic [15:0] a, input logic [7:0] idx,
                          input string tag, input bit toggle, input bit use_fix,
                          input logic [31:0] fixed);
        logic [31:0] e;
        int          en_cnt = 0;
        bit          got = 0;
        bit          en_prev;
        e = model_op(op, a, idx);
        if (use_fix) e = fixed;
        exp_q.push_back(e);
        @(negedge clk);
        start  = 1'b1;
        clk_en = 1'b1;
        dataa  = {16'h0, a};
        datab  = {16'h0, idx, 6'h0, op};
        en_prev = 1'b1;
        for (int c = 0; c < 400 && !got; c++) begin
            @(negedge clk);
            if (en_prev) en_cnt++;
            if (done) begin
                got = 1'b1;
                check({tag, "/result"}, result, exp_q.pop_front());
                check({tag, "/latency"}, en_cnt, (op == 2'b00) ? 32'd34 : 32'd1);
            end else begin
                start  = 1'b0;
                clk_en = toggle ? 1'($urandom_range(0, 1)) : 1'b1;
                if (toggle && op == 2'b00 && en_cnt == 5 && clk_en) begin
                    start = 1'b1;
                    datab = {16'h0, 8'd1, 6'h0, 2'b01};
                    dataa = 32'h0000_1234;
                end
                en_prev = clk_en;
            end
        end
        check({tag, "/done_seen"}, {31'h0, got}, 32'd1);
        if (!got) void'(exp_q.pop_front());
        start  = 1'b0;
        clk_en = 1'b1;
        @(negedge clk);
        check({tag, "/done_pulse"}, {31'h0, done}, 32'd0);
        check({tag, "/result_hold"}, result, e);
    endtask

    initial begin
        bit seen;
        reset  = 1'b1;
        clk_en = 1'b0;
        start  = 1'b0;
        dataa  = '0;
        datab  = '0;
        model_reset();
        repeat (3) @(negedge clk);
        reset = 1'b0;
        check("reset/result", result, 32'h0);
        check("reset/done", {31'h0, done}, 32'd0);

        // All coefficients zero.
        run_op(2'b00, 16'h4000, 8'd0, "filt_zero_coef", 1'b0, 1'b1, 32'h0000_0000);

        // Unity-ish coefficient on tap 0, read it back.
        run_op(2'b01, 16'h7FFF, 8'd0, "wr_c0", 1'b0, 1'b1, 32'h0);
        run_op(2'b00, 16'h4000, 8'd0, "filt_c0", 1'b0, 1'b1, 32'h0000_4000);
        run_op(2'b11, 16'h0000, 8'd0, "rd_c0", 1'b0, 1'b1, 32'h0000_7FFF);

        // Three-sample delay through coef[3].
        run_op(2'b10, 16'h0, 8'd0, "clr1", 1'b0, 1'b1, 32'h0);
        run_op(2'b01, 16'h0000, 8'd0, "wr_c0_zero", 1'b0, 1'b0, 32'h0);
        run_op(2'b01, 16'h7FFF, 8'd3, "wr_c3", 1'b0, 1'b0, 32'h0);
        run_op(2'b00, 16'h7FFF, 8'd0, "delay0", 1'b0, 1'b1, 32'h0);
        run_op(2'b00, 16'h0000, 8'd0, "delay1", 1'b0, 1'b1, 32'h0);
        run_op(2'b00, 16'h0000, 8'd0, "delay2", 1'b0, 1'b1, 32'h0);
        run_op(2'b00, 16'h0000, 8'd0, "delay3", 1'b0, 1'b1, 32'h0000_7FFE);
        run_op(2'b00, 16'h0000, 8'd0, "delay4", 1'b0, 1'b1, 32'h0);

        // Positive and negative saturation.
        for (int i = 0; i < TAPS; i++)
            run_op(2'b01, 16'h7FFF, 8'(i), $sformatf("wr_all%0d", i), 1'b0, 1'b0, 32'h0);
        for (int i = 0; i < TAPS; i++)
            run_op(2'b00, 16'h7FFF, 8'd0, $sformatf("sat_pos%0d", i), 1'b0,
                   (i == TAPS - 1), 32'h0000_7FFF);
        for (int i = 0; i < TAPS; i++)
            run_op(2'b00, 16'h8000, 8'd0, $sformatf("sat_neg%0d", i), 1'b0,
                   (i == TAPS - 1), 32'hFFFF_8000);

        // Index taken modulo TAPS, negative coefficient sign-extends on read.
        run_op(2'b01, 16'h8001, 8'd37, "wr_c37", 1'b0, 1'b0, 32'h0);
        run_op(2'b11, 16'h0000, 8'd5, "rd_c5", 1'b0, 1'b1, 32'hFFFF_8001);

        // Gapped clock enable plus a stray start while busy; coef[1] must remain untouched.
        run_op(2'b00, 16'h1234, 8'd0, "toggle_en", 1'b1, 1'b0, 32'h0);
        run_op(2'b11, 16'h0000, 8'd1, "rd_c1_after_stray", 1'b0, 1'b1, 32'h0000_7FFF);

        // Reset while the MAC loop is at k=10.
        @(negedge clk);
        start  = 1'b1;
        clk_en = 1'b1;
        dataa  = 32'h0000_4000;
        datab  = 32'h0;
        @(negedge clk);
        start = 1'b0;
        repeat (10) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        model_reset();
        seen = 1'b0;
        repeat (40) begin
            @(negedge clk);
            if (done) seen = 1'b1;
        end
        check("abort/no_done", {31'h0, seen}, 32'd0);
        check("abort/result", result, 32'h0);
        run_op(2'b01, 16'h7FFF, 8'd0, "abort_wr_c0", 1'b0, 1'b0, 32'h0);
        run_op(2'b00, 16'h4000, 8'd0, "abort_filt", 1'b0, 1'b1, 32'h0000_4000);

        // Random coefficients, 40 filter steps across the wr_ptr wrap.
        for (int i = 0; i < TAPS; i++)
            run_op(2'b01, 16'($urandom), 8'(i), $sformatf("rnd_c%0d", i), 1'b0, 1'b0, 32'h0);
        for (int i = 0; i < 40; i++)
            run_op(2'b00, 16'($urandom), 8'd0, $sformatf("rnd_f%0d", i), 1'b0, 1'b0, 32'h0);
        run_op(2'b10, 16'h0, 8'd0, "clr2", 1'b0, 1'b1, 32'h0);
        run_op(2'b00, 16'h0000, 8'd0, "filt_after_clr", 1'b0, 1'b1, 32'h0);

        check("scoreboard_empty", exp_q.size(), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
